// File: rtl/ibex_fetch_port_arbiter.sv
// Shares one in-order instruction-memory port between the fetch prefetcher and an auxiliary port.
// A small source-ID FIFO steers each response back to whichever requester issued it.
module ibex_fetch_port_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned StarveLimit    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_gnt_o,
    output logic        fetch_rvalid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    input  logic        aux_req_i,
    input  logic [31:0] aux_addr_i,
    output logic        aux_gnt_o,
    output logic        aux_rvalid_o,
    output logic [31:0] aux_rdata_o,
    output logic        aux_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        busy_o,
    output logic        protocol_err_o
);

    localparam int unsigned CountW = $clog2(MaxOutstanding + 1);
    localparam int unsigned Depth  = 1 << CountW;

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCK_FETCH,
        LOCK_AUX
    } lock_e;

    lock_e              lock_q, lock_d;
    logic [CountW-1:0]  count_q, count_d;
    logic [Depth-1:0]   ids_q, ids_d;
    logic [3:0]         starve_q, starve_d;
    logic               proto_err_q;

    logic               lock_hold;
    logic               forced;
    logic               sel_fetch;
    logic               sel_aux;
    logic               not_full;
    logic               push;
    logic               pop;
    logic [CountW-1:0]  wr_idx;

    assign lock_hold = (lock_q == LOCK_FETCH && fetch_req_i) || (lock_q == LOCK_AUX && aux_req_i);
    assign forced    = (starve_q == 4'(StarveLimit)) && aux_req_i;

    // A held lock keeps its requester selected until granted or the request is withdrawn;
    // nothing is selected while reset is asserted so every output reads zero.
    always_comb begin
        sel_fetch = 1'b0;
        sel_aux   = 1'b0;
        if (rst_ni) begin
            if (lock_hold) begin
                sel_fetch = (lock_q == LOCK_FETCH);
                sel_aux   = (lock_q == LOCK_AUX);
            end else if (fetch_req_i && !forced) begin
                sel_fetch = 1'b1;
            end else if (aux_req_i) begin
                sel_aux = 1'b1;
            end
        end
    end

    assign not_full    = count_q < CountW'(MaxOutstanding);
    assign mem_req_o   = (sel_fetch || sel_aux) && not_full;
    assign mem_addr_o  = sel_fetch ? fetch_addr_i : (sel_aux ? aux_addr_i : 32'h0);
    assign fetch_gnt_o = mem_gnt_i && mem_req_o && sel_fetch;
    assign aux_gnt_o   = mem_gnt_i && mem_req_o && sel_aux;

    assign push = fetch_gnt_o || aux_gnt_o;
    assign pop  = mem_rvalid_i && (count_q != '0);

    assign fetch_rvalid_o = pop && !ids_q[0];
    assign aux_rvalid_o   = pop && ids_q[0];
    assign fetch_rdata_o  = fetch_rvalid_o ? mem_rdata_i : 32'h0;
    assign fetch_err_o    = fetch_rvalid_o && mem_err_i;
    assign aux_rdata_o    = aux_rvalid_o ? mem_rdata_i : 32'h0;
    assign aux_err_o      = aux_rvalid_o && mem_err_i;

    assign busy_o         = (count_q != '0) || (lock_q != UNLOCKED);
    assign protocol_err_o = proto_err_q;

    // Source-ID FIFO kept as a shift register with the head in bit 0.
    always_comb begin
        ids_d  = ids_q;
        wr_idx = count_q - CountW'(pop);
        if (pop) begin
            ids_d = ids_q >> 1;
        end
        if (push) begin
            ids_d[wr_idx] = aux_gnt_o;
        end
        count_d = count_q + CountW'(push) - CountW'(pop);
    end

    // Lock and starvation bookkeeping for the next cycle.
    always_comb begin
        lock_d = UNLOCKED;
        if (mem_req_o && !mem_gnt_i) begin
            lock_d = sel_fetch ? LOCK_FETCH : LOCK_AUX;
        end
        starve_d = starve_q;
        if (!aux_req_i || aux_gnt_o) begin
            starve_d = 4'd0;
        end else if (fetch_gnt_o && starve_q != 4'(StarveLimit)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q      <= UNLOCKED;
            count_q     <= '0;
            ids_q       <= '0;
            starve_q    <= 4'd0;
            proto_err_q <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            count_q  <= count_d;
            ids_q    <= ids_d;
            starve_q <= starve_d;
            if (mem_rvalid_i && count_q == '0) begin
                proto_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ibex_fetch_port_arbiter.sv
// Randomised and directed bench for ibex_fetch_port_arbiter: a queue-based reference model predicts
// requests and grants each cycle, and a separate monitor checks responses against a scoreboard.
module tb_ibex_fetch_port_arbiter;

    localparam int MAX_OUT      = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct {
        int          src;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = 32'h0;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        fetch_err;
    logic        aux_req = 1'b0;
    logic [31:0] aux_addr = 32'h0;
    logic        aux_gnt;
    logic        aux_rvalid;
    logic [31:0] aux_rdata;
    logic        aux_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_err = 1'b0;
    logic        busy;
    logic        protocol_err;

    int    tests = 0;
    int    fails = 0;

    int    srcq[$];
    resp_t sb[$];
    int    lock_src = -1;
    int    starve = 0;
    bit    model_perr = 1'b0;
    bit    last_fg;
    bit    last_ag;
    resp_t mon_r;

    ibex_fetch_port_arbiter #(
        .MaxOutstanding(MAX_OUT),
        .StarveLimit   (STARVE_LIMIT)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .fetch_req_i   (fetch_req),
        .fetch_addr_i  (fetch_addr),
        .fetch_gnt_o   (fetch_gnt),
        .fetch_rvalid_o(fetch_rvalid),
        .fetch_rdata_o (fetch_rdata),
        .fetch_err_o   (fetch_err),
        .aux_req_i     (aux_req),
        .aux_addr_i    (aux_addr),
        .aux_gnt_o     (aux_gnt),
        .aux_rvalid_o  (aux_rvalid),
        .aux_rdata_o   (aux_rdata),
        .aux_err_o     (aux_err),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .mem_err_i     (mem_err),
        .busy_o        (busy),
        .protocol_err_o(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare the combinational outputs with the model, then advance the model.
    task automatic apply_stimulus(input logic fr, input logic [31:0] fa, input logic ar,
                                  input logic [31:0] aa, input logic g, input logic rv,
                                  input logic [31:0] rd, input logic er);
        int    sel;
        bit    lock_ok;
        bit    force_aux;
        bit    exp_req;
        resp_t r;
        @(negedge clk);
        fetch_req  = fr;
        fetch_addr = fa;
        aux_req    = ar;
        aux_addr   = aa;
        mem_gnt    = g;
        mem_rvalid = rv;
        mem_rdata  = rd;
        mem_err    = er;
        #1;
        lock_ok   = (lock_src == 0 && fr) || (lock_src == 1 && ar);
        force_aux = (starve == STARVE_LIMIT) && ar;
        if (lock_ok)                 sel = lock_src;
        else if (fr && !force_aux)   sel = 0;
        else if (ar)                 sel = 1;
        else                         sel = -1;
        exp_req = (sel >= 0) && (srcq.size() < MAX_OUT);
        last_fg = exp_req && g && sel == 0;
        last_ag = exp_req && g && sel == 1;
        check_output("mem_req", {31'h0, mem_req}, {31'h0, exp_req});
        check_output("mem_addr", mem_addr, sel == 0 ? fa : (sel == 1 ? aa : 32'h0));
        check_output("fetch_gnt", {31'h0, fetch_gnt}, {31'h0, last_fg});
        check_output("aux_gnt", {31'h0, aux_gnt}, {31'h0, last_ag});
        check_output("busy", {31'h0, busy}, {31'h0, (srcq.size() != 0 || lock_src >= 0)});
        check_output("protocol_err", {31'h0, protocol_err}, {31'h0, model_perr});
        if (rv) begin
            if (srcq.size() > 0) begin
                r.src  = srcq.pop_front();
                r.data = rd;
                r.err  = er;
                sb.push_back(r);
            end else begin
                model_perr = 1'b1;
            end
        end
        if (last_fg) srcq.push_back(0);
        if (last_ag) srcq.push_back(1);
        lock_src = (exp_req && !g) ? sel : -1;
        if (!ar || last_ag) starve = 0;
        else if (last_fg && starve < STARVE_LIMIT) starve++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && srcq.size() > 0; i++)
            apply_stimulus(0, 0, 0, 0, 0, 1, $urandom, 1'($urandom));
    endtask

    // Hold reset with every input active; all outputs must stay zero and all tracking is discarded.
    task automatic reset_dut();
        @(negedge clk);
        rst_n      = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0444;
        aux_req    = 1'b1;
        aux_addr   = 32'h0000_0888;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        mem_err    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_output("rst_outputs",
                         {20'h0, fetch_gnt, fetch_rvalid, fetch_err, aux_gnt, aux_rvalid, aux_err,
                          mem_req, busy, protocol_err, 3'h0},
                         32'h0);
            check_output("rst_data", fetch_rdata | aux_rdata | mem_addr, 32'h0);
            @(negedge clk);
        end
        fetch_req  = 1'b0;
        aux_req    = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        srcq.delete();
        lock_src   = -1;
        starve     = 0;
        model_perr = 1'b0;
        rst_n      = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        #2;
        if (fetch_rvalid || aux_rvalid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_rvalid: got fetch=%b aux=%b expected none at %0t",
                         fetch_rvalid, aux_rvalid, $time);
            end else begin
                mon_r = sb.pop_front();
                check_output("rsp_port", {30'h0, fetch_rvalid, aux_rvalid},
                             mon_r.src == 0 ? 32'h2 : 32'h1);
                check_output("rsp_data", mon_r.src == 0 ? fetch_rdata : aux_rdata, mon_r.data);
                check_output("rsp_err", {31'h0, mon_r.src == 0 ? fetch_err : aux_err},
                             {31'h0, mon_r.err});
                check_output("rsp_other_zero",
                             mon_r.src == 0 ? (aux_rdata | {31'h0, aux_err})
                                            : (fetch_rdata | {31'h0, fetch_err}),
                             32'h0);
            end
        end else if (sb.size() != 0) begin
            mon_r = sb.pop_front();
            tests++;
            fails++;
            $display("[TB] FAIL missing_rvalid: got none expected src %0d data %h at %0t",
                     mon_r.src, mon_r.data, $time);
        end
    end

    initial begin
        bit          fp;
        bit          ap;
        logic [31:0] fa;
        logic [31:0] aa;

        reset_dut();
        idle(2);

        // Fetch-only stream with one-cycle response latency.
        for (int i = 0; i < 5; i++)
            apply_stimulus(i < 3, 32'h100 + 32'(4 * i), 0, 0, 1, (i >= 1 && i <= 3),
                           32'hD000_0000 + 32'(i), 0);
        idle(2);

        // Both requesters always pending, memory always grants and answers next cycle.
        for (int i = 0; i < 20; i++)
            apply_stimulus(1, 32'h1000 + 32'(4 * i), 1, 32'h8000_0000 + 32'(4 * i), 1,
                           srcq.size() > 0, $urandom, 0);
        drain();
        idle(1);

        // Fetch stalled by memory while aux arrives: the lock must hold fetch until its grant.
        apply_stimulus(1, 32'h200, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 32'h200, 1, 32'h300, 0, 0, 0, 0);
        apply_stimulus(1, 32'h200, 1, 32'h300, 0, 0, 0, 0);
        apply_stimulus(1, 32'h200, 1, 32'h300, 1, 0, 0, 0);
        apply_stimulus(0, 0, 1, 32'h300, 1, 0, 0, 0);
        drain();

        // Fill to capacity, then answer fetch then aux (with error).
        apply_stimulus(1, 32'h400, 0, 0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 1, 32'h500, 1, 0, 0, 0);
        apply_stimulus(1, 32'h404, 1, 32'h504, 1, 0, 0, 0);
        apply_stimulus(1, 32'h404, 1, 32'h504, 1, 1, 32'hAAAA_0001, 0);
        apply_stimulus(1, 32'h404, 1, 32'h504, 1, 1, 32'hAAAA_0002, 1);
        drain();
        idle(1);

        // Spurious response with nothing outstanding sets the sticky error.
        apply_stimulus(0, 0, 0, 0, 0, 1, 32'h5555_5555, 0);
        idle(3);

        // Randomised traffic: requesters hold req and address stable until granted.
        fp = 0;
        ap = 0;
        fa = 0;
        aa = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!fp && ($urandom % 4) != 0) begin
                fp = 1;
                fa = $urandom & 32'hFFFF_FFFC;
            end
            if (!ap && ($urandom % 3) == 0) begin
                ap = 1;
                aa = $urandom & 32'hFFFF_FFFC;
            end
            apply_stimulus(fp, fa, ap, aa, ($urandom % 4) != 0,
                           srcq.size() > 0 && ($urandom % 3) != 0, $urandom, 1'($urandom));
            if (last_fg) fp = 0;
            if (last_ag) ap = 0;
        end
        drain();
        idle(1);

        // Reset with two transactions outstanding, then a late response arrives.
        apply_stimulus(1, 32'h600, 0, 0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 1, 32'h700, 1, 0, 0, 0);
        reset_dut();
        idle(1);
        apply_stimulus(0, 0, 0, 0, 0, 1, 32'h7777_7777, 0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
